sensor_scan_scheduler: RTL and testbench



---
 rtl/sensor_pkg.sv | 25 ++
 rtl/sensor_period_timer.sv | 29 ++
 rtl/sensor_scan_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sensor_scan_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and default constants for the colour-sensor scan scheduler.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BSY,
    RUN,
    BACKOFF,
    CLOSE
  } sched_state_e;

  typedef enum logic [1:0] {
    OK,
    NACK,
    TIMEOUT
  } frame_status_e;

  localparam int unsigned PERIOD_W_DEF     = 16;
  localparam int unsigned RETRY_MAX_DEF    = 3;
  localparam int unsigned BACKOFF_CYC_DEF  = 200;
  localparam int unsigned START_TO_CYC_DEF = 1023;
  localparam int unsigned RUN_TO_CYC_DEF   = 65535;

endpackage

// File: rtl/sensor_period_timer.sv
// Free-running scan period counter; tick marks the last cycle of a period.
module sensor_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period_cfg,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] last;

  // A zero period behaves as a one-cycle period.
  assign last = (period_cfg == '0) ? '0 : period_cfg - PERIOD_W'(1);
  assign tick = en && (cnt == last);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Launches one I2C sensor frame at a time, retries NACKs after a backoff.
// SENSOR_SCHED_WATCHDOG_EN builds the start/run watchdogs behind err_timeout.
module sensor_scan_scheduler
  import sensor_pkg::*;
#(
  parameter int unsigned PERIOD_W     = PERIOD_W_DEF,
  parameter int unsigned RETRY_MAX    = RETRY_MAX_DEF,
  parameter int unsigned BACKOFF_CYC  = BACKOFF_CYC_DEF,
  parameter int unsigned START_TO_CYC = START_TO_CYC_DEF,
  parameter int unsigned RUN_TO_CYC   = RUN_TO_CYC_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                periodic_en,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic                host_req,
  input  logic                bsy,
  input  logic                nack,
  output logic                senzor_on,
  output logic                frame_done,
  output logic                frame_ok,
  output logic                err_nack,
  output logic                err_timeout,
  output logic [1:0]          retry_cnt,
  output logic [15:0]         frame_cnt,
  output logic                active
);

  localparam logic [1:0]  RMAX    = 2'(RETRY_MAX);
  localparam logic [15:0] BO_LAST = 16'(BACKOFF_CYC - 1);

  sched_state_e  state, state_d;
  frame_status_e st_d;
  logic          host_pend, per_pend;
  logic          clr_host, clr_per;
  logic          tick;
  logic          nack_seen, nack_hit;
  logic [1:0]    retries;
  logic [15:0]   bo_cnt;
  logic          wd_start_exp, wd_run_exp;

  sensor_period_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (periodic_en),
    .period_cfg(period_cfg),
    .tick      (tick)
  );

`ifdef SENSOR_SCHED_WATCHDOG_EN
  localparam logic [15:0] START_LIM = 16'(START_TO_CYC);
  localparam logic [15:0] RUN_LIM   = 16'(RUN_TO_CYC);

  logic [15:0] wd;

  // Restarted at launch and again when bsy rises, so each phase has its own limit.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state == LAUNCH || (state == WAIT_BSY && bsy)) begin
      wd <= '0;
    end else begin
      wd <= wd + 16'd1;
    end
  end

  assign wd_start_exp = (wd == START_LIM);
  assign wd_run_exp   = (wd == RUN_LIM);
`else
  assign wd_start_exp = 1'b0;
  assign wd_run_exp   = 1'b0;
`endif

  // The transmitter drops nack together with bsy, so count the fall cycle too.
  assign nack_hit = nack_seen | nack;

  always_comb begin
    state_d  = state;
    st_d     = OK;
    clr_host = 1'b0;
    clr_per  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bsy && (host_pend || per_pend)) begin
          state_d  = LAUNCH;
          clr_host = host_pend;
          clr_per  = !host_pend;
        end
      end
      LAUNCH: state_d = WAIT_BSY;
      WAIT_BSY: begin
        if (bsy) begin
          state_d = RUN;
        end else if (wd_start_exp) begin
          state_d = CLOSE;
          st_d    = TIMEOUT;
        end
      end
      RUN: begin
        if (!bsy) begin
          if (!nack_hit) begin
            state_d = CLOSE;
          end else if (retries < RMAX) begin
            state_d = BACKOFF;
          end else begin
            state_d = CLOSE;
            st_d    = NACK;
          end
        end else if (wd_run_exp) begin
          state_d = CLOSE;
          st_d    = TIMEOUT;
        end
      end
      BACKOFF: begin
        if (bo_cnt == BO_LAST) state_d = LAUNCH;
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      host_pend <= 1'b0;
      per_pend  <= 1'b0;
      nack_seen <= 1'b0;
      retries   <= '0;
      bo_cnt    <= '0;
    end else begin
      state     <= state_d;
      host_pend <= host_req | (host_pend & ~clr_host);
      per_pend  <= tick | (per_pend & ~clr_per);
      if (state == LAUNCH) begin
        nack_seen <= 1'b0;
      end else if (state == RUN && nack) begin
        nack_seen <= 1'b1;
      end
      bo_cnt <= (state == BACKOFF) ? bo_cnt + 16'd1 : '0;
      if (state == RUN && state_d == BACKOFF) begin
        retries <= retries + 2'd1;
      end else if (state == CLOSE) begin
        retries <= '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      senzor_on   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      retry_cnt   <= '0;
      frame_cnt   <= '0;
      active      <= 1'b0;
    end else begin
      senzor_on  <= (state_d == LAUNCH);
      frame_done <= (state_d == CLOSE);
      active     <= (state_d != IDLE);
      if (state_d == CLOSE) begin
        frame_ok    <= (st_d == OK);
        err_nack    <= (st_d == NACK);
        err_timeout <= (st_d == TIMEOUT);
        retry_cnt   <= retries;
        frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Directed bench for sensor_scan_scheduler with a small I2C transmitter model.
// Timeout checks follow SENSOR_SCHED_WATCHDOG_EN.
module tb_sensor_scan_scheduler;

  localparam int BO  = 200;
  localparam int STO = 1023;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        periodic_en = 1'b0;
  logic [15:0] period_cfg = '0;
  logic        host_req = 1'b0;
  logic        mdl_bsy = 1'b0;
  logic        frc_bsy = 1'b0;
  logic        nack = 1'b0;
  logic        bsy;
  logic        senzor_on, frame_done, frame_ok;
  logic        err_nack, err_timeout, active;
  logic [1:0]  retry_cnt;
  logic [15:0] frame_cnt;

  assign bsy = mdl_bsy | frc_bsy;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int n_launch = 0;
  int n_done = 0;
  int launch_t[64];
  int done_t[64];
  int bf_t[64];
  logic        d_ok[64];
  logic        d_en[64];
  logic        d_to[64];
  logic [1:0]  d_rc[64];
  logic [15:0] d_fc[64];
  int nack_first = 0;
  int attempt = 0;
  bit quiet = 1'b0;
  bit m_nk;
  int m_li;
  int b, nd, tq, g;

  sensor_scan_scheduler dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .periodic_en(periodic_en),
    .period_cfg (period_cfg),
    .host_req   (host_req),
    .bsy        (bsy),
    .nack       (nack),
    .senzor_on  (senzor_on),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_nack   (err_nack),
    .err_timeout(err_timeout),
    .retry_cnt  (retry_cnt),
    .frame_cnt  (frame_cnt),
    .active     (active)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {senzor_on, frame_done, frame_ok, err_nack, err_timeout,
            active, retry_cnt, frame_cnt};
  endfunction

  task automatic pulse_host();
    @(negedge clk_in);
    host_req = 1'b1;
    @(negedge clk_in);
    host_req = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int budget,
                           input string tag);
    for (int i = 0; i < budget && n_done < tgt; i++) @(negedge clk_in);
    chk(tag, n_done, tgt);
  endtask

  // Monitor: timestamps of launches and closed frames with their status.
  initial forever begin
    @(negedge clk_in);
    if (senzor_on === 1'b1 && n_launch < 64) begin
      launch_t[n_launch] = cyc;
      n_launch++;
    end
    if (frame_done === 1'b1 && n_done < 64) begin
      done_t[n_done] = cyc;
      d_ok[n_done] = frame_ok;
      d_en[n_done] = err_nack;
      d_to[n_done] = err_timeout;
      d_rc[n_done] = retry_cnt;
      d_fc[n_done] = frame_cnt;
      n_done++;
    end
  end

  // Transmitter model: bsy 3 cycles after start, optional nack mid-frame.
  initial forever begin
    @(negedge clk_in);
    if (senzor_on === 1'b1 && !quiet) begin
      m_nk = (attempt < nack_first);
      attempt++;
      repeat (3) @(negedge clk_in);
      m_li = n_launch - 1;
      mdl_bsy = 1'b1;
      repeat (10) @(negedge clk_in);
      nack = m_nk;
      repeat (5) @(negedge clk_in);
      mdl_bsy = 1'b0;
      nack = 1'b0;
      if (m_li >= 0 && m_li < 64) bf_t[m_li] = cyc;
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_outs", outs(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("idle_no_launch", n_launch, 0);
    chk("idle_active", active, 0);

    // Periodic scans, every frame ACKed.
    period_cfg = 16'd500;
    periodic_en = 1'b1;
    wait_done(3, 2000, "per_done");
    chk("per_gap1", launch_t[1] - launch_t[0], 500);
    chk("per_gap2", launch_t[2] - launch_t[1], 500);
    for (int i = 0; i < 3; i++) begin
      chk("per_ok", d_ok[i], 1);
      chk("per_rc", d_rc[i], 0);
      chk("per_fc", d_fc[i], i + 1);
    end
    chk("per_done_lat", done_t[0] - bf_t[0], 1);
    periodic_en = 1'b0;
    repeat (50) @(negedge clk_in);
    chk("per_stop", n_launch, 3);
    chk("per_idle", active, 0);

    // Host request and period tick land on the same edge.
    b = n_launch;
    nd = n_done;
    period_cfg = 16'd4;
    periodic_en = 1'b1;
    repeat (3) @(negedge clk_in);
    host_req = 1'b1;
    tq = cyc;
    @(negedge clk_in);
    host_req = 1'b0;
    periodic_en = 1'b0;
    wait_done(nd + 2, 400, "both_done");
    chk("both_lat", launch_t[b] - tq, 2);
    chk("both_gap", launch_t[b + 1] - done_t[nd], 2);
    chk("both_fc", frame_cnt, 5);
    repeat (50) @(negedge clk_in);
    chk("both_nl", n_launch, b + 2);

    // Two NACKs, then ACK.
    b = n_launch;
    nd = n_done;
    nack_first = 2;
    attempt = 0;
    pulse_host();
    wait_done(nd + 1, 1500, "n2_done");
    chk("n2_launches", n_launch - b, 3);
    chk("n2_bo1", launch_t[b + 1] - bf_t[b], BO + 1);
    chk("n2_bo2", launch_t[b + 2] - bf_t[b + 1], BO + 1);
    chk("n2_ok", d_ok[nd], 1);
    chk("n2_en", d_en[nd], 0);
    chk("n2_rc", d_rc[nd], 2);
    chk("n2_fc", d_fc[nd], 6);
    chk("n2_lat", done_t[nd] - bf_t[b + 2], 1);

    // NACK on every attempt.
    b = n_launch;
    nd = n_done;
    nack_first = 99;
    attempt = 0;
    pulse_host();
    wait_done(nd + 1, 2000, "nall_done");
    chk("nall_launches", n_launch - b, 4);
    chk("nall_ok", d_ok[nd], 0);
    chk("nall_en", d_en[nd], 1);
    chk("nall_to", d_to[nd], 0);
    chk("nall_rc", d_rc[nd], 3);
    nack_first = 0;

    // Foreign transfer holds bsy high in IDLE.
    b = n_launch;
    nd = n_done;
    @(negedge clk_in);
    frc_bsy = 1'b1;
    pulse_host();
    repeat (20) @(negedge clk_in);
    chk("frn_hold", n_launch, b);
    chk("frn_idle", active, 0);
    frc_bsy = 1'b0;
    g = cyc;
    wait_done(nd + 1, 200, "frn_done");
    chk("frn_lat", launch_t[b] - g, 1);
    chk("frn_ok", d_ok[nd], 1);

    // Reset while the frame is in RUN.
    b = n_launch;
    nd = n_done;
    pulse_host();
    for (int i = 0; i < 50 && !mdl_bsy; i++) @(negedge clk_in);
    chk("rr_bsy", mdl_bsy, 1);
    repeat (4) @(negedge clk_in);
    chk("rr_active", active, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_outs", outs(), 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_in);
    chk("rr_no_done", n_done, nd);
    chk("rr_no_launch", n_launch, b + 1);
    chk("rr_idle", active, 0);

    // Transmitter never answers.
    b = n_launch;
    nd = n_done;
    quiet = 1'b1;
    pulse_host();
`ifdef SENSOR_SCHED_WATCHDOG_EN
    wait_done(nd + 1, 1500, "wd_done");
    chk("wd_lat", done_t[nd] - launch_t[b], STO + 2);
    chk("wd_to", d_to[nd], 1);
    chk("wd_ok", d_ok[nd], 0);
    chk("wd_en", d_en[nd], 0);
    chk("wd_fc", d_fc[nd], 1);
`else
    repeat (1500) @(negedge clk_in);
    chk("nowd_launch", n_launch, b + 1);
    chk("nowd_done", n_done, nd);
    chk("nowd_active", active, 1);
    chk("nowd_to", err_timeout, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
